// File: rtl/io_mem_pkg.sv
// Shared types and defaults for the IO register requester: FSM encoding,
// bus width / window defaults and the address window decode.
package io_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_STB,
        ST_RD_STB,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    localparam int         DATA_W_DEF  = 16;
    localparam logic [7:0] IO_BASE_DEF = 8'h40;
    localparam logic [7:0] IO_MASK_DEF = 8'hF0;

    // Operands are zero-extended to 32 bits so one function serves any ADDR_W.
    function automatic logic io_win_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/io_req_fifo.sv
// Synchronous request FIFO. Full is registered from the next count so the
// upstream ready is a clean flop; a push is refused while full_o is high.
module io_req_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        full_d   = (count_d == (PTR_W+1)'(DEPTH));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/io_mem_requester.sv
// CPU-side requester for the 16-bit IO register slave: buffers requests,
// decodes the IO window, strobes the slave and returns one response each.
module io_mem_requester
    import io_mem_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                FIFO_DEPTH = 4,
    parameter int                RD_LAT     = 1,
    parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(IO_BASE_DEF),
    parameter logic [ADDR_W-1:0] IO_MASK    = ADDR_W'(IO_MASK_DEF)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_we,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              dev_read_en,
    output logic              dev_write_en,
    output logic [DATA_W-1:0] dev_wdata,
    input  logic [DATA_W-1:0] dev_rdata
);

    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t            state_q, state_d;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [ENT_W-1:0]  head;
    logic              head_we, head_hit;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    logic              we_q, err_q;
    logic [DATA_W-1:0] rdata_q, wdata_q;
    logic [CNT_W-1:0]  cnt_q;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

    io_req_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .push_i      (fifo_push),
        .push_data_i ({req_we, req_addr, req_wdata}),
        .pop_i       (fifo_pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign {head_we, head_addr, head_wdata} = head;
    assign head_hit = io_win_hit(32'(head_addr), 32'(IO_BASE), 32'(IO_MASK));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (!head_hit)    state_d = ST_RESP;
                    else if (head_we) state_d = ST_WR_STB;
                    else              state_d = ST_RD_STB;
                end
            end
            ST_WR_STB:  state_d = ST_RESP;
            ST_RD_STB:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (cnt_q == '0) state_d = ST_RESP;
            ST_RESP:    if (resp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Strobes and resp_valid decode straight from state so async reset kills them at once.
    always_comb begin
        dev_write_en = (state_q == ST_WR_STB);
        dev_read_en  = (state_q == ST_RD_STB);
        resp_valid   = (state_q == ST_RESP);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (fifo_pop) begin
                we_q    <= head_we;
                err_q   <= !head_hit;
                rdata_q <= '0;
                if (head_hit && head_we) begin
                    wdata_q <= head_wdata;
                end
            end
            if (state_q == ST_RD_STB) begin
                cnt_q <= CNT_W'(RD_LAT - 1);
            end else if (state_q == ST_RD_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (state_q == ST_RD_WAIT && cnt_q == '0) begin
                rdata_q <= dev_rdata;
            end
        end
    end

    assign resp_we    = we_q;
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;
    assign dev_wdata  = wdata_q;

endmodule

// File: tb/tb_io_mem_requester.sv
// Directed bench for io_mem_requester with RD_LAT=3 and a single-register
// slave model that only drives valid read data on the expected capture cycle.
module tb_io_mem_requester;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int RD_LAT     = 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid, resp_ready, resp_we, resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic              dev_read_en, dev_write_en;
    logic [DATA_W-1:0] dev_wdata, dev_rdata;

    io_mem_requester #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RD_LAT     (RD_LAT),
        .IO_BASE    (8'h40),
        .IO_MASK    (8'hF0)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_we      (resp_we),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .dev_read_en  (dev_read_en),
        .dev_write_en (dev_write_en),
        .dev_wdata    (dev_wdata),
        .dev_rdata    (dev_rdata)
    );

    always #5 CLK = ~CLK;

    // Slave: one register; read data is valid only RD_LAT cycles after the strobe.
    logic [DATA_W-1:0] slave_reg;
    logic [RD_LAT-1:0] rd_pipe;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            slave_reg <= '0;
            rd_pipe   <= '0;
        end else begin
            if (dev_write_en) slave_reg <= dev_wdata;
            rd_pipe <= {rd_pipe[RD_LAT-2:0], dev_read_en};
        end
    end
    assign dev_rdata = rd_pipe[RD_LAT-1] ? slave_reg : 16'hDEAD;

    int                wcnt = 0;
    int                rcnt = 0;
    int                hcnt = 0;
    logic [DATA_W-1:0] wlog [64];
    always @(posedge CLK) begin
        if (dev_write_en) begin
            wlog[wcnt % 64] <= dev_wdata;
            wcnt <= wcnt + 1;
        end
        if (dev_read_en) rcnt <= rcnt + 1;
        if (resp_valid && resp_ready) hcnt <= hcnt + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              err;
        logic [DATA_W-1:0] rdata;
        int                lat;
    } vec_t;

    // Issue one request with resp_ready=1 and check latency, strobes and response.
    task automatic run_vec(input vec_t v, input string tag);
        int first, nw, nr, wcyc, rcyc;
        logic rwe, rerr;
        logic [DATA_W-1:0] rrd, wd;
        first = 0; nw = 0; nr = 0; wcyc = 0; rcyc = 0;
        rwe = 1'b0; rerr = 1'b0; rrd = '0; wd = '0;
        req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1; resp_ready = 1'b1;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 15 && first == 0; c++) begin
            if (dev_write_en) begin nw++; wcyc = c; wd = dev_wdata; end
            if (dev_read_en)  begin nr++; rcyc = c; end
            if (resp_valid) begin
                first = c; rwe = resp_we; rerr = resp_err; rrd = resp_rdata;
            end
            tick();
        end
        check({tag, "_lat"}, 32'(first), 32'(v.lat));
        check({tag, "_resp"}, {15'd0, rwe, rerr, rrd}, {15'd0, v.we, v.err, v.rdata});
        check({tag, "_nwr"}, 32'(nw), (!v.err && v.we) ? 32'd1 : 32'd0);
        check({tag, "_nrd"}, 32'(nr), (!v.err && !v.we) ? 32'd1 : 32'd0);
        if (!v.err && v.we) begin
            check({tag, "_wcyc"}, 32'(wcyc), 32'd2);
            check({tag, "_wdata"}, 32'(wd), 32'(v.wdata));
        end
        if (!v.err && !v.we) check({tag, "_rcyc"}, 32'(rcyc), 32'd2);
        check({tag, "_drop"}, 32'(resp_valid), 32'd0);
    endtask

    vec_t vecs [11];

    initial begin
        int n, base, hb, rb, seen;
        logic r;

        vecs[0]  = '{1'b1, 8'h41, 16'hBEEF, 1'b0, 16'h0000, 3};
        vecs[1]  = '{1'b0, 8'h41, 16'h0000, 1'b0, 16'hBEEF, 3 + RD_LAT};
        vecs[2]  = '{1'b0, 8'h80, 16'h0000, 1'b1, 16'h0000, 2};
        vecs[3]  = '{1'b1, 8'h4F, 16'h1234, 1'b0, 16'h0000, 3};
        vecs[4]  = '{1'b0, 8'h42, 16'h0000, 1'b0, 16'h1234, 3 + RD_LAT};
        vecs[5]  = '{1'b1, 8'h30, 16'h5555, 1'b1, 16'h0000, 2};
        vecs[6]  = '{1'b0, 8'h4F, 16'h0000, 1'b0, 16'h1234, 3 + RD_LAT};
        vecs[7]  = '{1'b1, 8'hC0, 16'hAAAA, 1'b1, 16'h0000, 2};
        vecs[8]  = '{1'b0, 8'h3F, 16'h0000, 1'b1, 16'h0000, 2};
        vecs[9]  = '{1'b1, 8'h40, 16'h0001, 1'b0, 16'h0000, 3};
        vecs[10] = '{1'b0, 8'h4F, 16'h0000, 1'b0, 16'h0001, 3 + RD_LAT};

        RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; resp_ready = 1'b0;
        tick();
        tick();
        check("reset_ctrl", {27'd0, resp_valid, resp_we, resp_err, dev_read_en, dev_write_en}, 32'd0);
        check("reset_data", {resp_rdata, dev_wdata}, 32'd0);
        RST = 1'b0;
        tick();
        check("reset_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Response hold under resp_ready stall
        run_vec('{1'b1, 8'h44, 16'h1234, 1'b0, 16'h0000, 3}, "hold_wr");
        req_we = 1'b0; req_addr = 8'h44; req_valid = 1'b1; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        check("hold_arrive", 32'(resp_valid), 32'd1);
        hb = hcnt;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold_c%0d", k), {13'd0, resp_valid, resp_err, resp_we, resp_rdata},
                  {13'd0, 1'b1, 1'b0, 1'b0, 16'h1234});
            tick();
        end
        resp_ready = 1'b1;
        tick();
        tick();
        tick();
        check("hold_one_hs", 32'(hcnt - hb), 32'd1);
        check("hold_drop", 32'(resp_valid), 32'd0);

        // FIFO fill with response backpressure
        resp_ready = 1'b0;
        base = wcnt; hb = hcnt; n = 0;
        for (int k = 0; k < 10 && n < 6; k++) begin
            req_we = 1'b1;
            req_addr = 8'h40 + 8'(n);
            req_wdata = 16'hA000 + 16'(n);
            req_valid = 1'b1;
            r = req_ready;
            tick();
            if (r) n++;
        end
        check("full_accepted", 32'(n), 32'd5);
        check("full_ready", 32'(req_ready), 32'd0);
        check("full_inflight", 32'(wcnt - base), 32'd1);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        n = 0;
        while ((hcnt - hb) < 5 && n < 60) begin tick(); n++; end
        tick();
        tick();
        check("full_resps", 32'(hcnt - hb), 32'd5);
        check("full_strobes", 32'(wcnt - base), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("full_order%0d", i), 32'(wlog[(base + i) % 64]), 32'(16'hA000 + 16'(i)));
        check("full_ready_back", 32'(req_ready), 32'd1);

        // Reset during RD_WAIT with a second request queued
        req_we = 1'b0; req_addr = 8'h41; req_valid = 1'b1;
        tick();
        req_addr = 8'h42;
        tick();
        check("rstmid_strobe", 32'(dev_read_en), 32'd1);
        req_valid = 1'b0;
        tick();
        RST = 1'b1;
        #1;
        check("rstmid_drop", {30'd0, dev_read_en, resp_valid}, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        check("rstmid_ready", 32'(req_ready), 32'd1);
        check("rstmid_wdata", 32'(dev_wdata), 32'd0);
        rb = rcnt; hb = hcnt; seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (resp_valid || dev_read_en || dev_write_en) seen++;
            tick();
        end
        check("rstmid_quiet", 32'(seen), 32'd0);
        check("rstmid_nostale", 32'(rcnt - rb) + 32'(hcnt - hb), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
